// File: rtl/uart_byte_rx_pkg.sv
// uart_byte_rx_pkg: FSM state encoding, rate defaults and line constants shared by the UART receiver.
package uart_byte_rx_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam int   DEF_CLK_FREQ   = 50000000;
    localparam int   DEF_BAUD_RATE  = 115200;
    localparam int   DEF_OVERSAMPLE = 16;
    localparam logic LINE_IDLE      = 1'b1;
endpackage

// File: rtl/uart_os_tick_gen.sv
// uart_os_tick_gen: free-running divide-by-OS_DIV counter producing a one-cycle oversample tick.
module uart_os_tick_gen #(
    parameter int OS_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic os_tick
);
    localparam int CW = OS_DIV > 1 ? $clog2(OS_DIV) : 1;

    logic [CW-1:0] cnt;

    assign os_tick = cnt == CW'(OS_DIV - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= os_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: oversampled 8N1 UART byte receiver with mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_err port.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int OS_DIV     = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
`ifdef UART_RX_PARITY_EN
   ,output logic       parity_err
`endif
);
    localparam int TW = $clog2(OVERSAMPLE);

    if (OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0 || CLK_FREQ < BAUD_RATE * OVERSAMPLE) begin : g_param_check
        $error("uart_byte_rx: OVERSAMPLE must be even and >= 4, and fit within CLK_FREQ/BAUD_RATE");
    end

    state_t          state, nxt;
    logic [1:0]      sync;
    logic            rx_s, rx_prev, os_tick, mid_start, mid_bit;
    logic            take_byte, bad_stop, shift_en;
    logic [TW-1:0]   tick_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
`ifdef UART_RX_PARITY_EN
    logic            par_bad;
`endif

    uart_os_tick_gen #(.OS_DIV(OS_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .os_tick (os_tick)
    );

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync    <= {2{LINE_IDLE}};
            rx_prev <= LINE_IDLE;
        end else begin
            sync    <= {sync[0], rx_in};
            rx_prev <= rx_s;
        end

    // START restarts tick_cnt at its midpoint, so later bits are sampled at the wrap
    assign mid_start = os_tick && tick_cnt == TW'(OVERSAMPLE / 2 - 1);
    assign mid_bit   = os_tick && tick_cnt == TW'(OVERSAMPLE - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:   if (rx_prev && !rx_s) nxt = START;
            START:  if (mid_start) nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (mid_bit && bit_cnt == 3'd7) nxt = PARITY;
            PARITY: if (mid_bit) nxt = STOP;
`else
            DATA:   if (mid_bit && bit_cnt == 3'd7) nxt = STOP;
`endif
            STOP:   if (mid_bit) nxt = rx_s ? IDLE : BREAK;
            BREAK:  if (rx_s) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_busy   = state != IDLE;
        shift_en  = state == DATA && mid_bit;
        take_byte = state == STOP && mid_bit && rx_s;
        bad_stop  = state == STOP && mid_bit && !rx_s;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            tick_cnt   <= '0;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_valid  <= take_byte;
            frame_err <= bad_stop;
            if (take_byte) rx_data <= shift;
            if (state == IDLE || (state == START && mid_start)) tick_cnt <= '0;
            else if (os_tick) tick_cnt <= mid_bit ? '0 : tick_cnt + 1'b1;
            if (state == IDLE) bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shift[bit_cnt] <= rx_s;
`ifdef UART_RX_PARITY_EN
            // parity verdict is held so it lines up with the rx_valid strobe
            if (state == PARITY && mid_bit) par_bad <= ^{shift, rx_s};
            parity_err <= take_byte && par_bad;
`endif
        end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed loopback-style bench; the bench itself plays the byte transmitter at 4 clk/bit.
// Build with +define+UART_RX_PARITY_EN to exercise 8E1 frames and parity_err.
module tb_uart_byte_rx;
    localparam int OVS = 4;
`ifdef UART_RX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int LAT = FB * OVS + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0, errors = 0;
    int cyc = 0, last_valid_cyc = 0;
    int n_valid, n_ferr, n_both, n_perr, n_perr_valid;
    logic [7:0] got_q[$];

    uart_byte_rx #(.OVERSAMPLE(OVS), .OS_DIV(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
`ifdef UART_RX_PARITY_EN
       ,.parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n) begin
            if (rx_valid) begin
                n_valid++;
                got_q.push_back(rx_data);
                last_valid_cyc = cyc;
            end
            if (frame_err) n_ferr++;
            if (rx_valid && frame_err) n_both++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) n_perr++;
            if (parity_err && rx_valid) n_perr_valid++;
`endif
        end

    task automatic clear_mon();
        n_valid = 0; n_ferr = 0; n_both = 0; n_perr = 0; n_perr_valid = 0;
        got_q.delete();
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (OVS) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int bits);
        for (int i = 0; i < bits; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int stop_len);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bz) send_bit(1'b1);
`endif
        for (int i = 0; i < stop_len; i++) send_bit(stop);
    endtask

    task automatic test_reset();
        checks += 4;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy got %b want 0", rx_busy); end
`ifdef UART_RX_PARITY_EN
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
`endif
    endtask

    task automatic test_single();
        int t0;
        clear_mon();
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        idle(2);
        checks += 4;
        if (n_valid !== 1) begin errors++; $display("FAIL a5_valid_count got %0d want 1", n_valid); end
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", rx_data); end
        if (n_ferr !== 0) begin errors++; $display("FAIL a5_frame_err got %0d want 0", n_ferr); end
        if (last_valid_cyc - t0 !== LAT) begin errors++; $display("FAIL a5_latency got %0d want %0d", last_valid_cyc - t0, LAT); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(8'h00, 1'b0, 1'b1, 1);
        send_frame(8'hFF, 1'b0, 1'b1, 1);
        idle(2);
        checks += 3;
        if (n_valid !== 2) begin errors++; $display("FAIL b2b_valid_count got %0d want 2", n_valid); end
        if ((got_q.size() > 0 ? got_q[0] : 8'hxx) !== 8'h00) begin errors++; $display("FAIL b2b_first got %h want 00", got_q.size() > 0 ? got_q[0] : 8'hxx); end
        if ((got_q.size() > 1 ? got_q[1] : 8'hxx) !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", got_q.size() > 1 ? got_q[1] : 8'hxx); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx_in = 1'b0;
        @(posedge clk); #1;
        rx_in = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks += 4;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_start_busy got %b want 1", rx_busy); end
        idle(3);
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle_busy got %b want 0", rx_busy); end
        if (n_valid !== 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", n_valid); end
        if (n_ferr !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", n_ferr); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b0, 3);
        checks += 8;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL break_busy got %b want 1", rx_busy); end
        idle(2);
        if (n_ferr !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", n_ferr); end
        if (n_valid !== 0) begin errors++; $display("FAIL ferr_valid got %0d want 0", n_valid); end
        if (n_both !== 0) begin errors++; $display("FAIL ferr_overlap got %0d want 0", n_both); end
        if (rx_data !== 8'hFF) begin errors++; $display("FAIL ferr_data_held got %h want ff", rx_data); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_recover_busy got %b want 0", rx_busy); end
        clear_mon();
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        idle(2);
        if (n_valid !== 1) begin errors++; $display("FAIL after_ferr_valid got %0d want 1", n_valid); end
        if (rx_data !== 8'h5A) begin errors++; $display("FAIL after_ferr_data got %h want 5a", rx_data); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d = 8'h81;
        clear_mon();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_in = d[4];
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks += 8;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", rx_data); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", rx_busy); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", rx_valid); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
        rx_in = 1'b1;
        repeat (4) @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);
        if (n_valid !== 0) begin errors++; $display("FAIL midrst_no_strobe got %0d want 0", n_valid); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b want 0", rx_busy); end
        send_frame(d, 1'b0, 1'b1, 1);
        idle(2);
        if (n_valid !== 1) begin errors++; $display("FAIL post_rst_valid got %0d want 1", n_valid); end
        if (rx_data !== 8'h81) begin errors++; $display("FAIL post_rst_data got %h want 81", rx_data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_mon();
        send_frame(8'h07, 1'b0, 1'b1, 1);
        idle(2);
        checks += 6;
        if (n_valid !== 1) begin errors++; $display("FAIL par_bad_valid got %0d want 1", n_valid); end
        if (n_perr !== 1) begin errors++; $display("FAIL par_bad_count got %0d want 1", n_perr); end
        if (n_perr_valid !== 1) begin errors++; $display("FAIL par_bad_same_cycle got %0d want 1", n_perr_valid); end
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1, 1);
        idle(2);
        if (n_valid !== 1) begin errors++; $display("FAIL par_ok_valid got %0d want 1", n_valid); end
        if (n_perr !== 0) begin errors++; $display("FAIL par_ok_perr got %0d want 0", n_perr); end
        if (rx_data !== 8'h07) begin errors++; $display("FAIL par_ok_data got %h want 07", rx_data); end
    endtask
`endif

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        idle(2);
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
